axi_sram_responder: RTL
=======================

# axi_sram_responder

AXI4 responder that terminates CVA6 data and instruction traffic in a single-ported, word-addressed SRAM model. It sits on the far side of the core's AXI4 initiator port, in the SoC memory map or the bench, and decodes AW/W/AR requests into memory accesses and B/R responses. It serves one transaction at a time and supports FIXED/INCR bursts of up to 256 beats.

## Interface
- IdWidth, 4: AXI ID width.
- AddrWidth, 64: AXI address width.
- DataWidth, 64: AXI data width; beat size is DataWidth/8 bytes.
- MemBytes, 65536: SRAM capacity in bytes; must be a power of two and a multiple of DataWidth/8.
- BaseAddr, 64'h8000_0000: address of SRAM byte 0.

- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  synchronous, active-high reset.
- aw_valid_i / aw_ready_o  in/out  1  write-address handshake.
- aw_id_i  in  IdWidth  write ID. aw_addr_i  in  AddrWidth  write start address.
- aw_len_i  in  8  beats-1. aw_size_i  in  3  beat size. aw_burst_i  in  2  burst type. aw_atop_i  in  6  atomic opcode.
- w_valid_i / w_ready_o  in/out  1  write-data handshake. w_data_i  in  DataWidth. w_strb_i  in  DataWidth/8. w_last_i  in  1  (ignored, see Operation).
- b_valid_o / b_ready_i  out/in  1  write-response handshake. b_id_o  out  IdWidth. b_resp_o  out  2.
- ar_valid_i / ar_ready_o  in/out  1  read-address handshake. ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i  in  as AW.
- r_valid_o / r_ready_i  out/in  1  read-data handshake. r_id_o  out  IdWidth. r_data_o  out  DataWidth. r_resp_o  out  2. r_last_o  out  1.

## Operation
- FSM states: IDLE, WDATA, WRESP, RDATA. Reset state IDLE.
- IDLE arbitration: only AW valid → grant write; only AR valid → grant read; both valid → grant the type not granted last. The last-granted flag resets to "read", so writes win the first tie.
- In IDLE, the granted channel's ready is 1 and the other is 0. With no valid input, aw_ready_o = 1 and ar_ready_o = 0.
- Latched on an address handshake: id, start address, len, size, burst, and for writes the atop value. The beat counter is cleared.
- Beat address:
  - INCR: start address aligned down to DataWidth/8, plus beat×DataWidth/8.
  - FIXED: the aligned start address on every beat.
  - 4 KiB crossing is not checked.
  - Word index = (beat address − BaseAddr) >> log2(DataWidth/8).
- Beat error (SLVERR, 2'b10) if any of:
  - burst = WRAP or reserved;
  - size ≠ log2(DataWidth/8);
  - write with atop ≠ 0;
  - beat address < BaseAddr or ≥ BaseAddr+MemBytes.
- WDATA:
  - w_ready_o = 1; each W handshake is one beat.
  - Non-error beat: write the SRAM bytes selected by w_strb_i.
  - Error beat: no SRAM change.
  - The burst ends after len+1 beats; w_last_i is not checked.
  - After the final beat, go to WRESP.
- WRESP:
  - b_valid_o = 1 with the latched id.
  - b_resp_o = SLVERR if any beat of the burst erred, else OKAY.
  - Held stable until b_ready_i; then go to IDLE.
- RDATA:
  - r_valid_o = 1, r_id_o = latched id, r_last_o = 1 on beat len.
  - Non-error beat: r_data_o = SRAM word, r_resp_o = OKAY.
  - Error beat: r_data_o = 0, r_resp_o = SLVERR.
  - Outputs are held until r_ready_i. After the last handshake, go to IDLE.
- SRAM contents are not initialised and are unaffected by reset.

## Timing
- Reset values: aw_ready_o = 0, w_ready_o = 0, b_valid_o = 0, ar_ready_o = 0, r_valid_o = 0, r_last_o = 0, b_resp_o = 0, r_resp_o = 0, r_data_o = 0, b_id_o = 0, r_id_o = 0, state = IDLE, last-granted = read. Ready outputs take their IDLE values from the first cycle after reset deasserts.
- Write path:
  - AW handshake in cycle N → w_ready_o = 1 from cycle N+1.
  - Final W handshake in cycle M → b_valid_o = 1 in cycle M+1.
  - B handshake in cycle K → IDLE in K+1; the next address can be accepted in K+1.
- Read path:
  - AR handshake in cycle N → the SRAM read of beat 0 is registered at the clock edge closing N → r_valid_o = 1 with beat 0 in cycle N+1.
  - An R handshake in cycle K presents the next beat in K+1, with no bubble, giving 1 beat/cycle under continuous r_ready_i.
  - Last R handshake in cycle K → IDLE in K+1.
- Minimum transaction gap: 1 IDLE cycle between the end of one transaction and the next address handshake.
- No outputs depend combinationally on *_valid_i or *_ready_i, except the IDLE grant, which depends on aw_valid_i and ar_valid_i.
- rst_i asserted mid-burst: the burst is aborted at the next edge. No B or R beat is emitted afterwards. SRAM writes already completed remain.

## Test plan
- Single write then read:
  - Stimulus: AW addr 0x8000_0010, len 0, size 3, INCR; W data 0x1122_3344_5566_7788, strb 0xFF.
  - Required: B OKAY in the cycle after the W handshake.
  - Then AR to the same address → r_data_o = 0x1122_3344_5566_7788, r_last_o = 1, one cycle after the AR handshake.
- Byte strobes:
  - Stimulus: write 0xFFFF_FFFF_FFFF_FFFF with strb 0xFF, then 0x0 with strb 0x0F, to the same word.
  - Required: a read returns 0xFFFF_FFFF_0000_0000.
- INCR burst with backpressure:
  - Stimulus: 4-beat write at 0x8000_0100 with data 1,2,3,4. Then a 4-beat read with r_ready_i low every other cycle.
  - Required: R beats 1,2,3,4 with r_last_o only on beat 4, and data held stable while stalled.
- Simultaneous requests after reset:
  - Stimulus: AW and AR valid in the same cycle.
  - Required: write granted first; the read is served afterwards. The next tie grants the read.
- Errors:
  - Read at 0x8001_0000 with len 1 → two SLVERR beats with data 0.
  - WRAP write → SLVERR B and unchanged SRAM.
  - aw_atop_i = 6'h20 → SLVERR B and no write.
- Reset mid-read:
  - Stimulus: assert rst_i during beat 2 of an 8-beat read.
  - Required: r_valid_o = 0 the next cycle and no further R beats. A following 1-beat read completes normally.

Source files
------------

// File: rtl/axi_sram_responder.sv
// AXI4 responder terminating one transaction at a time in a word-addressed SRAM model.
module axi_sram_responder #(
   parameter int unsigned          IdWidth   = 4,
   parameter int unsigned          AddrWidth = 64,
   parameter int unsigned          DataWidth = 64,
   parameter int unsigned          MemBytes  = 65536,
   parameter logic [AddrWidth-1:0] BaseAddr  = 64'h8000_0000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   aw_valid_i,
   output logic                   aw_ready_o,
   input  logic [IdWidth-1:0]     aw_id_i,
   input  logic [AddrWidth-1:0]   aw_addr_i,
   input  logic [7:0]             aw_len_i,
   input  logic [2:0]             aw_size_i,
   input  logic [1:0]             aw_burst_i,
   input  logic [5:0]             aw_atop_i,
   input  logic                   w_valid_i,
   output logic                   w_ready_o,
   input  logic [DataWidth-1:0]   w_data_i,
   input  logic [DataWidth/8-1:0] w_strb_i,
   input  logic                   w_last_i,
   output logic                   b_valid_o,
   input  logic                   b_ready_i,
   output logic [IdWidth-1:0]     b_id_o,
   output logic [1:0]             b_resp_o,
   input  logic                   ar_valid_i,
   output logic                   ar_ready_o,
   input  logic [IdWidth-1:0]     ar_id_i,
   input  logic [AddrWidth-1:0]   ar_addr_i,
   input  logic [7:0]             ar_len_i,
   input  logic [2:0]             ar_size_i,
   input  logic [1:0]             ar_burst_i,
   output logic                   r_valid_o,
   input  logic                   r_ready_i,
   output logic [IdWidth-1:0]     r_id_o,
   output logic [DataWidth-1:0]   r_data_o,
   output logic [1:0]             r_resp_o,
   output logic                   r_last_o
);

   localparam int unsigned BeatBytes = DataWidth / 8;
   localparam int unsigned SizeLog   = $clog2(BeatBytes);
   localparam int unsigned Words     = MemBytes / BeatBytes;
   localparam int unsigned IdxWidth  = $clog2(Words);
   localparam logic [1:0]  BurstFixed = 2'b00;
   localparam logic [1:0]  BurstIncr  = 2'b01;
   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlverr = 2'b10;
   localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(BeatBytes - 1);
   localparam logic [AddrWidth-1:0] LimitAddr = BaseAddr + AddrWidth'(MemBytes);

   typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

   state_t                 state_q, state_d;
   logic                   last_write_q;
   logic [IdWidth-1:0]     id_q;
   logic [AddrWidth-1:0]   addr_q;
   logic [7:0]             len_q;
   logic [2:0]             size_q;
   logic [1:0]             burst_q;
   logic                   atop_bad_q;
   logic [7:0]             beat_q;
   logic                   err_acc_q;
   logic [DataWidth-1:0]   r_data_q;
   logic [1:0]             r_resp_q;
   logic [DataWidth-1:0]   mem_q [Words];

   logic                   grant_r_c, aw_hs_c, ar_hs_c, last_beat_c;
   logic [AddrWidth-1:0]   wr_addr_c, rd_addr_c;
   logic                   wr_err_c, rd_err_c;
   logic [IdxWidth-1:0]    wr_idx_c, rd_idx_c;
   logic                   unused_w_last;

   assign unused_w_last = w_last_i;

   function automatic logic [AddrWidth-1:0] beat_addr(input logic [AddrWidth-1:0] start,
                                                      input logic [1:0] burst, input logic [7:0] beat);
      logic [AddrWidth-1:0] aligned;
      aligned = start & AlignMask;
      if (burst == BurstFixed) return aligned;
      return aligned + (AddrWidth'(beat) << SizeLog);
   endfunction

   function automatic logic beat_err(input logic [AddrWidth-1:0] addr, input logic [1:0] burst,
                                     input logic [2:0] size, input logic atop_bad);
      return ((burst != BurstFixed) && (burst != BurstIncr)) || (size != 3'(SizeLog)) ||
             atop_bad || (addr < BaseAddr) || (addr >= LimitAddr);
   endfunction

   function automatic logic [IdxWidth-1:0] word_idx(input logic [AddrWidth-1:0] addr);
      return IdxWidth'((addr - BaseAddr) >> SizeLog);
   endfunction

   // IDLE arbitration: alternate on a tie, writes win the first one
   assign grant_r_c   = ar_valid_i && (!aw_valid_i || last_write_q);
   assign aw_hs_c     = aw_valid_i && aw_ready_o;
   assign ar_hs_c     = ar_valid_i && ar_ready_o;
   assign last_beat_c = (beat_q == len_q);

   // Beat address/error for the current write beat and the next read beat to fetch
   always_comb begin
      wr_addr_c = beat_addr(addr_q, burst_q, beat_q);
      wr_err_c  = beat_err(wr_addr_c, burst_q, size_q, atop_bad_q);
      wr_idx_c  = word_idx(wr_addr_c);
      rd_addr_c = beat_addr(addr_q, burst_q, beat_q + 8'd1);
      rd_err_c  = beat_err(rd_addr_c, burst_q, size_q, 1'b0);
      if (state_q == IDLE) begin
         rd_addr_c = beat_addr(ar_addr_i, ar_burst_i, 8'd0);
         rd_err_c  = beat_err(rd_addr_c, ar_burst_i, ar_size_i, 1'b0);
      end
      rd_idx_c = word_idx(rd_addr_c);
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (aw_hs_c) state_d = WDATA;
                  else if (ar_hs_c) state_d = RDATA;
         WDATA:   if (w_valid_i && last_beat_c) state_d = WRESP;
         WRESP:   if (b_ready_i) state_d = IDLE;
         RDATA:   if (r_ready_i && last_beat_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode; everything is quiet while reset is held
   always_comb begin
      aw_ready_o = 1'b0;
      ar_ready_o = 1'b0;
      w_ready_o  = 1'b0;
      b_valid_o  = 1'b0;
      b_resp_o   = RespOkay;
      r_valid_o  = 1'b0;
      r_last_o   = 1'b0;
      b_id_o     = id_q;
      r_id_o     = id_q;
      r_data_o   = r_data_q;
      r_resp_o   = r_resp_q;
      if (!rst_i) begin
         case (state_q)
            IDLE: begin
               aw_ready_o = !grant_r_c;
               ar_ready_o = grant_r_c;
            end
            WDATA: w_ready_o = 1'b1;
            WRESP: begin
               b_valid_o = 1'b1;
               b_resp_o  = err_acc_q ? RespSlverr : RespOkay;
            end
            RDATA: begin
               r_valid_o = 1'b1;
               r_last_o  = last_beat_c;
            end
            default: ;
         endcase
      end
   end

   // Transaction context, beat counter and registered read data
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_write_q <= 1'b0;
         id_q         <= '0;
         addr_q       <= '0;
         len_q        <= '0;
         size_q       <= '0;
         burst_q      <= '0;
         atop_bad_q   <= 1'b0;
         beat_q       <= '0;
         err_acc_q    <= 1'b0;
         r_data_q     <= '0;
         r_resp_q     <= RespOkay;
      end else if (aw_hs_c) begin
         last_write_q <= 1'b1;
         id_q         <= aw_id_i;
         addr_q       <= aw_addr_i;
         len_q        <= aw_len_i;
         size_q       <= aw_size_i;
         burst_q      <= aw_burst_i;
         atop_bad_q   <= (aw_atop_i != 6'd0);
         beat_q       <= '0;
         err_acc_q    <= 1'b0;
      end else if (ar_hs_c) begin
         last_write_q <= 1'b0;
         id_q         <= ar_id_i;
         addr_q       <= ar_addr_i;
         len_q        <= ar_len_i;
         size_q       <= ar_size_i;
         burst_q      <= ar_burst_i;
         atop_bad_q   <= 1'b0;
         beat_q       <= '0;
         r_data_q     <= rd_err_c ? '0 : mem_q[rd_idx_c];
         r_resp_q     <= rd_err_c ? RespSlverr : RespOkay;
      end else if ((state_q == WDATA) && w_valid_i) begin
         beat_q <= beat_q + 8'd1;
         if (wr_err_c) err_acc_q <= 1'b1;
      end else if ((state_q == RDATA) && r_ready_i && !last_beat_c) begin
         beat_q   <= beat_q + 8'd1;
         r_data_q <= rd_err_c ? '0 : mem_q[rd_idx_c];
         r_resp_q <= rd_err_c ? RespSlverr : RespOkay;
      end
   end

   // SRAM byte-enable write port; contents survive reset
   always_ff @(posedge clk_i) begin
      if (!rst_i && (state_q == WDATA) && w_valid_i && !wr_err_c) begin
         for (int unsigned b = 0; b < BeatBytes; b++) begin
            if (w_strb_i[b]) mem_q[wr_idx_c][8*b +: 8] <= w_data_i[8*b +: 8];
         end
      end
   end

endmodule
